// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: request/grant and shared-register bus between two requesters and the arbiter.
interface reg_write_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic             en;
  logic             busy;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] wr_count;
  modport master (
    output req0, req1, data0, data1,
    input  gnt0, gnt1, en, busy, d, q, wr_count
  );
  modport slave (
    input  req0, req1, data0, data1,
    output gnt0, gnt1, en, busy, d, q, wr_count
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter granting one of two requesters a single-cycle write
// into an internal shared enable-D register, with a completed-write counter.
module reg_write_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  reg_write_arbiter_if.slave bus
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_req;
  assign any_req = bus.req0 | bus.req1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb state_d = (state_q == IDLE && any_req) ? WRITE : IDLE;
  // last resets to 1 so requester 0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 1'b0;
      last_q <= 1'b1;
      d_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
    end else begin
      sel_q  <= sel_d;
      last_q <= last_d;
      d_q    <= d_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
    end
  end
  // d_q is cleared on leaving WRITE so the d output reads 0 in IDLE
  always_comb begin
    sel_d  = sel_q;
    last_d = last_q;
    d_d    = d_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    if (state_q == IDLE && any_req) begin
      sel_d = bus.req1 & (~bus.req0 | ~last_q);
      d_d   = sel_d ? bus.data1 : bus.data0;
    end
    if (state_q == WRITE) begin
      q_d    = d_q;
      cnt_d  = CNT_W'(cnt_q + 1'b1);
      last_d = sel_q;
      d_d    = '0;
    end
  end
  always_comb begin
    bus.en       = (state_q == WRITE);
    bus.busy     = bus.en;
    bus.gnt0     = bus.en & ~sel_q;
    bus.gnt1     = bus.en & sel_q;
    bus.d        = d_q;
    bus.q        = q_q;
    bus.wr_count = cnt_q;
  end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed and randomized checks of reg_write_arbiter against a
// transaction-level model of the write protocol.
module tb_reg_write_arbiter;
  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  reg_write_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  reg_write_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  bit       m_busy, m_sel, m_last;
  bit [3:0] m_d, m_q;
  int       m_writes;
  wire [13:0] obs = {bus.gnt0, bus.gnt1, bus.en, bus.busy, bus.d, bus.q, bus.wr_count};
  function automatic logic [13:0] expv();
    return {m_busy && !m_sel, m_busy && m_sel, m_busy, m_busy,
            m_busy ? m_d : 4'h0, m_q, 2'(m_writes % 4)};
  endfunction
  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_last = 1; m_d = 0; m_q = 0; m_writes = 0;
  endtask
  task automatic model_edge();
    if (!rst_n) model_reset();
    else if (m_busy) begin
      m_q = m_d; m_writes++; m_last = m_sel; m_busy = 0;
    end else if (bus.req0 || bus.req1) begin
      m_sel  = (bus.req0 && bus.req1) ? !m_last : bus.req1;
      m_d    = m_sel ? bus.data1 : bus.data0;
      m_busy = 1;
    end
  endtask
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic drive(input bit r0, input bit [3:0] d0, input bit r1, input bit [3:0] d1);
    bus.req0 = r0; bus.data0 = d0; bus.req1 = r1; bus.data1 = d1;
  endtask
  task automatic do_reset();
    rst_n = 0; model_reset();
    cycle();
    rst_n = 1;
  endtask
  task automatic test_reset();
    drive(1, 4'hF, 0, 4'h0);
    rst_n = 0; model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (obs !== 14'h0) begin n_err++; $display("FAIL reset_hold got=%h exp=%h", obs, 14'h0); end
    end
    rst_n = 1;
    cycle();
    n_cmp++;
    if (bus.gnt0 !== 1'b1 || obs !== expv()) begin
      n_err++; $display("FAIL reset_release got=%h exp=%h", obs, expv());
    end
    drive(0, 4'h0, 0, 4'h0);
    cycle();
  endtask
  task automatic test_single();
    do_reset();
    drive(1, 4'hA, 0, 4'h0);
    cycle();
    n_cmp++;
    if (obs !== expv() || {bus.gnt0, bus.en, bus.d} !== 6'b11_1010) begin
      n_err++; $display("FAIL single_grant got=%h exp=%h", obs, expv());
    end
    drive(0, 4'h0, 0, 4'h0);
    cycle();
    n_cmp++;
    if (obs !== expv() || bus.q !== 4'hA || bus.wr_count !== 2'd1) begin
      n_err++; $display("FAIL single_done got=%h exp=%h", obs, expv());
    end
  endtask
  task automatic test_round_robin();
    logic [3:0] exp_q[3] = '{4'h3, 4'hC, 4'h3};
    do_reset();
    drive(1, 4'h3, 1, 4'hC);
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (obs !== expv() || {bus.gnt0, bus.gnt1} !== ((i % 2) ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL rr_grant%0d got=%h exp=%h", i, obs, expv());
      end
      cycle();
      n_cmp++;
      if (obs !== expv() || bus.q !== exp_q[i] || bus.en !== 1'b0) begin
        n_err++; $display("FAIL rr_q%0d got=%h exp=%h q_req=%h", i, obs, expv(), exp_q[i]);
      end
    end
    drive(0, 4'h0, 0, 4'h0);
  endtask
  task automatic test_data_change();
    do_reset();
    drive(0, 4'h0, 1, 4'h5);
    cycle();
    drive(1, 4'h2, 1, 4'h9);
    n_cmp++;
    #2;
    if (obs !== expv() || bus.d !== 4'h5) begin
      n_err++; $display("FAIL dchg_d got=%h exp=%h", obs, expv());
    end
    cycle();
    drive(0, 4'h0, 0, 4'h0);
    n_cmp++;
    if (obs !== expv() || bus.q !== 4'h5) begin
      n_err++; $display("FAIL dchg_q got=%h exp=%h", obs, expv());
    end
    cycle();
  endtask
  task automatic test_reset_mid_write();
    do_reset();
    drive(1, 4'h7, 0, 4'h0);
    cycle();
    drive(0, 4'h0, 0, 4'h0);
    #2;
    rst_n = 0; model_reset();
    #1;
    n_cmp++;
    if (obs !== 14'h0) begin n_err++; $display("FAIL reset_mid_write got=%h exp=%h", obs, 14'h0); end
    cycle();
    rst_n = 1;
    cycle();
    n_cmp++;
    if (obs !== 14'h0) begin n_err++; $display("FAIL reset_abort got=%h exp=%h", obs, 14'h0); end
  endtask
  task automatic test_wrap();
    logic [1:0] exp_cnt[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'(i + 1), 0, 4'h0);
      cycle();
      drive(0, 4'h0, 0, 4'h0);
      cycle();
      n_cmp++;
      if (obs !== expv() || bus.wr_count !== exp_cnt[i]) begin
        n_err++; $display("FAIL wrap%0d got=%h exp=%h cnt_req=%0d", i, obs, expv(), exp_cnt[i]);
      end
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 0; model_reset();
        #1;
        rst_n = 1;
      end
      cycle();
      n_cmp++;
      if (obs !== expv() || (bus.gnt0 && bus.gnt1)) begin
        n_err++; $display("FAIL random%0d got=%h exp=%h", i, obs, expv());
      end
    end
    drive(0, 4'h0, 0, 4'h0);
  endtask
  initial begin
    drive(0, 4'h0, 0, 4'h0);
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_data_change();
    test_reset_mid_write();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
